// File: rtl/ln_2to1.sv
// ln_2to1 -- two-input to one-output 4-phase req/ack link merger.
// Each message (addr, dat) from input 0 or input 1 is forwarded unmodified
// to the single downstream link. Simultaneous requests are resolved
// round-robin. Input 0 wins the first tie after reset.
// Optional build macro: LN_2TO1_SYNC_EN adds a 2-flop synchronizer on
// i_0_req, i_1_req and i_ack so sources and sink may run on unrelated clocks.
`timescale 1ns/1ps

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module ln_2to1 #(
    parameter int ASZ = `ADDRESS_SIZE,
    parameter int DSZ = `DATA_SIZE
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [ASZ-1:0] i_0_addr,
    input  logic [DSZ-1:0] i_0_dat,
    input  logic           i_0_req,
    output logic           o_0_ack,
    input  logic [ASZ-1:0] i_1_addr,
    input  logic [DSZ-1:0] i_1_dat,
    input  logic           i_1_req,
    output logic           o_1_ack,
    output logic [ASZ-1:0] o_addr,
    output logic [DSZ-1:0] o_dat,
    output logic           o_req,
    input  logic           i_ack,
    output logic           o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OUT_REQ = 2'd1,
        OUT_REL = 2'd2,
        IN_REL  = 2'd3
    } state_t;

    // Handshake inputs as seen by the FSM: bit 0 = req_0, 1 = req_1, 2 = ack_s
    logic [2:0] hs_raw;
    logic [2:0] hs_sampled;
    logic       req_0;
    logic       req_1;
    logic       ack_s;

    assign hs_raw = {i_ack, i_1_req, i_0_req};

`ifdef LN_2TO1_SYNC_EN
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchronizer; data lines need none because the
            // protocol holds them stable while req is high.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= hs_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign hs_sampled[gi] = sync_reg;
        end
    endgenerate
`else
    assign hs_sampled = hs_raw;
`endif

    assign req_0 = hs_sampled[0];
    assign req_1 = hs_sampled[1];
    assign ack_s = hs_sampled[2];

    state_t         state_reg,      state_next;
    logic           last_grant_reg, last_grant_next;
    logic           sel_reg,        sel_next;
    logic [ASZ-1:0] addr_reg,       addr_next;
    logic [DSZ-1:0] dat_reg,        dat_next;
    logic           req_out_reg,    req_out_next;
    logic           ack0_reg,       ack0_next;
    logic           ack1_reg,       ack1_next;
    logic           grant_sel;
    logic           req_sel;

    // State and registered outputs; everything clears asynchronously so a
    // reset mid-transfer abandons the message instead of replaying it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            sel_reg        <= 1'b0;
            addr_reg       <= '0;
            dat_reg        <= '0;
            req_out_reg    <= 1'b0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            sel_reg        <= sel_next;
            addr_reg       <= addr_next;
            dat_reg        <= dat_next;
            req_out_reg    <= req_out_next;
            ack0_reg       <= ack0_next;
            ack1_reg       <= ack1_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, then walk the downstream and
    // upstream handshakes for the granted input.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        sel_next        = sel_reg;
        addr_next       = addr_reg;
        dat_next        = dat_reg;
        req_out_next    = req_out_reg;
        ack0_next       = ack0_reg;
        ack1_next       = ack1_reg;
        grant_sel       = 1'b0;
        req_sel         = sel_reg ? req_1 : req_0;

        case (state_reg)
            IDLE: begin
                if (req_0 || req_1) begin
                    // A tie goes to whichever input was not served last.
                    grant_sel       = (req_0 && req_1) ? ~last_grant_reg : req_1;
                    sel_next        = grant_sel;
                    last_grant_next = grant_sel;
                    addr_next       = grant_sel ? i_1_addr : i_0_addr;
                    dat_next        = grant_sel ? i_1_dat  : i_0_dat;
                    req_out_next    = 1'b1;
                    state_next      = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_s) begin
                    req_out_next = 1'b0;
                    if (sel_reg) begin
                        ack1_next = 1'b1;
                    end else begin
                        ack0_next = 1'b1;
                    end
                    state_next = OUT_REL;
                end
            end
            OUT_REL: begin
                if (!ack_s) begin
                    state_next = IN_REL;
                end
            end
            IN_REL: begin
                if (!req_sel) begin
                    ack0_next  = 1'b0;
                    ack1_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_addr  = addr_reg;
    assign o_dat   = dat_reg;
    assign o_req   = req_out_reg;
    assign o_0_ack = ack0_reg;
    assign o_1_ack = ack1_reg;
    assign o_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ln_2to1.sv
// tb_ln_2to1 -- directed self-checking bench for the ln_2to1 link merger.
// Acts as both upstream sources and the downstream sink; drives on the
// falling edge and samples on the falling edge, away from the active edge.
`timescale 1ns/1ps

module tb_ln_2to1;

`ifdef LN_2TO1_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a0, d0, a1, d1, oa, od;
    logic       r0, r1, k0, k1, oreq, iack, busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ln_2to1 #(.ASZ(8), .DSZ(8)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_0_addr (a0),
        .i_0_dat  (d0),
        .i_0_req  (r0),
        .o_0_ack  (k0),
        .i_1_addr (a1),
        .i_1_dat  (d1),
        .i_1_req  (r1),
        .o_1_ack  (k1),
        .o_addr   (oa),
        .o_dat    (od),
        .o_req    (oreq),
        .i_ack    (iack),
        .o_busy   (busy)
    );

    function automatic logic mon(input int sel);
        case (sel)
            0:       return oreq;
            1:       return k0;
            2:       return k1;
            default: return busy;
        endcase
    endfunction

    // Bounded wait on a DUT output; ok=0 means the bound expired.
    task automatic wait_for(input int sel, input logic val, input int max, output bit ok);
        int n;
        n = 0;
        while (mon(sel) !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        ok = (mon(sel) === val);
    endtask

    // Sink acks, source of input src releases, wait for the upstream ack to fall.
    task automatic finish_xfer(input int src, output bit ok);
        bit ok1, ok2;
        iack = 1'b1;
        wait_for(src + 1, 1'b1, 20, ok1);
        iack = 1'b0;
        if (src == 0) r0 = 1'b0; else r1 = 1'b0;
        wait_for(src + 1, 1'b0, 20, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic do_reset();
        r0 = 1'b0; r1 = 1'b0; iack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0 = i[0]; r1 = ~i[0]; iack = i[1];
            a0 = 8'(i + 3); d0 = 8'(i + 7); a1 = 8'(i + 11); d1 = 8'(i + 13);
        end
        @(negedge clk);
        checks++;
        if ({oreq, k0, k1} !== 3'b000) $display("FAIL reset_ctrl: req/ack0/ack1=%b expected 000", {oreq, k0, k1});
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected 0", busy);
        else passes++;
        checks++;
        if ({oa, od} !== 16'h0000) $display("FAIL reset_data: addr=%h dat=%h expected 00 00", oa, od);
        else passes++;
        r0 = 1'b0; r1 = 1'b0; iack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        r0 = 1'b1; a0 = 8'h01; d0 = 8'h03;
        n = 0;
        while (oreq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (oreq !== 1'b1 || n != LAT) $display("FAIL reset_latency: o_req=%b after %0d cycles expected 1 after %0d", oreq, n, LAT);
        else passes++;
        finish_xfer(0, ok);
        checks++;
        if (!ok) $display("FAIL reset_handshake: handshake ok=%0d expected 1", ok);
        else passes++;
        $display("xfer reset-release src=0 addr=%h dat=%h", oa, od);
    endtask

    task automatic test_single_in0();
        bit ok;
        r0 = 1'b1; a0 = 8'd2; d0 = 8'd7;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok) $display("FAIL single_req: o_req=%b expected 1", oreq);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({oreq, k0, k1} !== 3'b100) $display("FAIL single_hold: req/ack0/ack1=%b expected 100", {oreq, k0, k1});
            else passes++;
        end
        iack = 1'b1;
        wait_for(1, 1'b1, 10, ok);
        checks++;
        if (!ok || k1 !== 1'b0 || oreq !== 1'b0) $display("FAIL single_ack: ack0=%b ack1=%b req=%b expected 1 0 0", k0, k1, oreq);
        else passes++;
        checks++;
        if (oa !== 8'd2 || od !== 8'd7) $display("FAIL single_data: addr=%h dat=%h expected 02 07", oa, od);
        else passes++;
        iack = 1'b0; r0 = 1'b0;
        wait_for(1, 1'b0, 10, ok);
        checks++;
        if (!ok || busy !== 1'b0) $display("FAIL single_idle: ack0=%b busy=%b expected 0 0", k0, busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (oa !== 8'd2 || od !== 8'd7) $display("FAIL single_hold_data: addr=%h dat=%h expected 02 07", oa, od);
        else passes++;
        $display("xfer single src=0 addr=%h dat=%h", oa, od);
    endtask

    task automatic test_tie();
        bit ok;
        do_reset();
        r0 = 1'b1; a0 = 8'h50; d0 = 8'd5;
        r1 = 1'b1; a1 = 8'h90; d1 = 8'd9;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok || od !== 8'd5 || oa !== 8'h50) $display("FAIL tie_first: req=%b addr=%h dat=%h expected 1 50 05", oreq, oa, od);
        else passes++;
        $display("xfer tie src=0 addr=%h dat=%h", oa, od);
        finish_xfer(0, ok);
        checks++;
        if (!ok || k1 !== 1'b0) $display("FAIL tie_hs0: ok=%0d ack1=%b expected 1 0", ok, k1);
        else passes++;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok || od !== 8'd9 || oa !== 8'h90) $display("FAIL tie_second: req=%b addr=%h dat=%h expected 1 90 09", oreq, oa, od);
        else passes++;
        $display("xfer tie src=1 addr=%h dat=%h", oa, od);
        finish_xfer(1, ok);
        checks++;
        if (!ok || k0 !== 1'b0) $display("FAIL tie_hs1: ok=%0d ack0=%b expected 1 0", ok, k0);
        else passes++;
    endtask

    task automatic test_contention();
        bit ok;
        int src, idx, cnt0, cnt1;
        logic [7:0] exp_a, exp_d;
        do_reset();
        cnt0 = 0; cnt1 = 0;
        r0 = 1'b1; a0 = 8'h10; d0 = 8'h00;
        r1 = 1'b1; a1 = 8'h20; d1 = 8'h80;
        for (int i = 0; i < 16; i++) begin
            src = i % 2;
            idx = i / 2;
            exp_a = (src == 0) ? 8'(8'h10 + idx) : 8'(8'h20 + idx);
            exp_d = (src == 0) ? 8'(idx) : 8'(8'h80 + idx);
            wait_for(0, 1'b1, 20, ok);
            checks++;
            if (!ok || oa !== exp_a || od !== exp_d) $display("FAIL contention_msg%0d: req=%b addr=%h dat=%h expected 1 %h %h", i, oreq, oa, od, exp_a, exp_d);
            else passes++;
            $display("xfer contention #%0d src=%0d addr=%h dat=%h", i, src, oa, od);
            iack = 1'b1;
            wait_for(src + 1, 1'b1, 20, ok);
            checks++;
            if (!ok || mon(2 - src) !== 1'b0) $display("FAIL contention_ack%0d: ack0=%b ack1=%b expected src %0d only", i, k0, k1, src);
            else passes++;
            iack = 1'b0;
            if (src == 0) begin r0 = 1'b0; cnt0++; end
            else begin r1 = 1'b0; cnt1++; end
            wait_for(src + 1, 1'b0, 20, ok);
            checks++;
            if (!ok) $display("FAIL contention_rel%0d: ack still high, expected 0", i);
            else passes++;
            if (src == 0 && cnt0 < 8) begin
                r0 = 1'b1; a0 = 8'(8'h10 + cnt0); d0 = 8'(cnt0);
            end
            if (src == 1 && cnt1 < 8) begin
                r1 = 1'b1; a1 = 8'(8'h20 + cnt1); d1 = 8'(8'h80 + cnt1);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (oreq !== 1'b0 || busy !== 1'b0) $display("FAIL contention_drain: req=%b busy=%b expected 0 0 after 16 messages", oreq, busy);
        else passes++;
    endtask

    task automatic test_slow_release();
        bit ok;
        r1 = 1'b1; a1 = 8'h05; d1 = 8'h06;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok || od !== 8'h06) $display("FAIL slow_grant: req=%b dat=%h expected 1 06", oreq, od);
        else passes++;
        iack = 1'b1;
        wait_for(2, 1'b1, 10, ok);
        checks++;
        if (!ok) $display("FAIL slow_ack: ack1=%b expected 1", k1);
        else passes++;
        iack = 1'b0;
        r0 = 1'b1; a0 = 8'h0A; d0 = 8'h0B;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({k1, oreq, k0} !== 3'b100) $display("FAIL slow_hold%0d: ack1/req/ack0=%b expected 100", i, {k1, oreq, k0});
            else passes++;
        end
        r1 = 1'b0;
        wait_for(2, 1'b0, 10, ok);
        checks++;
        if (!ok) $display("FAIL slow_release: ack1=%b expected 0", k1);
        else passes++;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok || oa !== 8'h0A || od !== 8'h0B) $display("FAIL slow_next: req=%b addr=%h dat=%h expected 1 0a 0b", oreq, oa, od);
        else passes++;
        $display("xfer slow-release src=0 addr=%h dat=%h", oa, od);
        finish_xfer(0, ok);
        checks++;
        if (!ok) $display("FAIL slow_next_hs: ok=%0d expected 1", ok);
        else passes++;
    endtask

    task automatic test_mid_reset();
        bit ok;
        r0 = 1'b1; a0 = 8'h44; d0 = 8'h55;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok || busy !== 1'b1) $display("FAIL midrst_pre: req=%b busy=%b expected 1 1", oreq, busy);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({oreq, k0, k1, busy} !== 4'b0000 || oa !== 8'h00 || od !== 8'h00)
            $display("FAIL midrst_async: req/ack0/ack1/busy=%b addr=%h dat=%h expected 0000 00 00", {oreq, k0, k1, busy}, oa, od);
        else passes++;
        r0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r0 = 1'b1; a0 = 8'h09; d0 = 8'h33;
        wait_for(0, 1'b1, 10, ok);
        checks++;
        if (!ok || oa !== 8'h09 || od !== 8'h33) $display("FAIL midrst_post: req=%b addr=%h dat=%h expected 1 09 33", oreq, oa, od);
        else passes++;
        $display("xfer post-reset src=0 addr=%h dat=%h", oa, od);
        finish_xfer(0, ok);
        checks++;
        if (!ok) $display("FAIL midrst_hs: ok=%0d expected 1", ok);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b0; r0 = 1'b0; r1 = 1'b0; iack = 1'b0;
        a0 = 8'h00; d0 = 8'h00; a1 = 8'h00; d1 = 8'h00;
        test_reset();
        test_single_in0();
        test_tie();
        test_contention();
        test_slow_release();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ln_2to1.md
Name: ln_2to1

Overview:
- 2-input to 1-output link merger. It is the converging counterpart of the 1-to-2 splitter.
- It accepts messages (addr, dat) from two upstream 4-phase req/ack links and forwards each one, unmodified, onto a single downstream 4-phase link.
- Round-robin arbitration applies when both inputs request at once.
- Sits between splitter outputs (or any two sources) and a single sink, e.g. to recombine traffic in link-network tests.

Parameters:
- ASZ, `ADDRESS_SIZE, width of address field.
- DSZ, `DATA_SIZE, width of data field.

Ports:
- i_clk  in  1  block clock
- i_rst_n  in  1  asynchronous active-low reset
- i_0_addr  in  ASZ  input 0 address, stable while i_0_req=1
- i_0_dat  in  DSZ  input 0 data, stable while i_0_req=1
- i_0_req  in  1  input 0 request
- o_0_ack  out  1  input 0 acknowledge
- i_1_addr  in  ASZ  input 1 address
- i_1_dat  in  DSZ  input 1 data
- i_1_req  in  1  input 1 request
- o_1_ack  out  1  input 1 acknowledge
- o_addr  out  ASZ  output address (registered)
- o_dat  out  DSZ  output data (registered)
- o_req  out  1  output request
- i_ack  in  1  output acknowledge from sink
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: o_0_ack=0, o_1_ack=0, o_req=0, o_addr=0, o_dat=0, o_busy=0, state=IDLE, last_grant=1 (input 0 wins first tie).
- Protocol, all links 4-phase:
  - Sender raises req with addr/dat stable.
  - Receiver raises ack.
  - Sender drops req.
  - Receiver drops ack.
  - Next req is allowed only after ack is low.
- Sampled inputs: req_0, req_1, ack_s are the (optionally synchronized, see below) versions of i_0_req, i_1_req, i_ack.
- FSM states: IDLE, OUT_REQ, OUT_REL, IN_REL.
- IDLE:
  - If req_0 or req_1 is high, pick sel. If only one is high, take that one. If both are high, take !last_grant.
  - Register o_addr/o_dat from the selected input and set o_req=1, last_grant=sel, go to OUT_REQ. All of this happens in one edge.
  - With no request, stay in IDLE.
- OUT_REQ: hold o_req=1 and the data. When ack_s=1: o_req<=0, o_<sel>_ack<=1, go to OUT_REL.
- OUT_REL: wait for ack_s=0, then go to IN_REL.
- IN_REL: wait for req_<sel>=0, then o_<sel>_ack<=0, go to IDLE.
- Latency (no sync): req seen at edge N gives o_req=1 after edge N, i.e. 1 cycle.
- Ack on the non-selected input stays 0 throughout.
- o_addr/o_dat hold their last forwarded value after the transfer. They change only on the IDLE grant edge.
- No reordering within one input. Each input is fully handshaken before its next message is accepted.
- Fairness: with both inputs continuously requesting, grants alternate 0,1,0,1.
- Simultaneous events:
  - A req arriving on the other input during a transfer waits in IDLE for arbitration. It is never lost, because the sender holds req.
  - If req_<sel> drops before ack_s falls, that is legal. IN_REL then exits on its first cycle.
- Reset mid-operation: all outputs return to reset values immediately (async). No partial message is replayed. The upstream sender must restart its handshake.
- Protocol violation (req dropped before ack): undefined, not detected.

Optional Feature:
- LN_2TO1_SYNC_EN:
  - Defined: i_0_req, i_1_req and i_ack each pass through a 2-flop synchronizer (reset to 0) before the FSM. This allows sources and sink on unrelated clocks. Add 2 cycles to each handshake-phase response, so IDLE→o_req takes 3 cycles.
  - Undefined: those inputs drive the FSM directly, and all links must share i_clk.
  - Data inputs are never synchronized. The protocol guarantees their stability while req is high.

Test Plan (each line: stimulus -> required response):
- Reset: assert i_rst_n=0 while inputs are toggling -> all outputs 0 and o_busy=0. Release, then raise i_0_req -> o_req=1 one cycle later (no sync).
- Single input 0: addr=2, dat=7, sink acks after 3 cycles -> o_addr=2, o_dat=7, o_0_ack rises after i_ack, o_1_ack stays 0. Full handshake completes and FSM is back in IDLE.
- Tie after reset: both req raised on the same edge (in0 dat=5, in1 dat=9) -> first forwarded dat=5, then dat=9.
- Continuous contention: 8 messages per input -> output sequence alternates 0,1,0,1…, 16 messages total, none duplicated or lost.
- Slow source release: hold i_1_req high 10 cycles after o_1_ack -> o_1_ack stays high and no new grant occurs until i_1_req=0.
- Mid-transfer reset: assert reset in OUT_REQ -> o_req and acks drop asynchronously. A post-reset transfer forwards the new data correctly.
- LN_2TO1_SYNC_EN build: repeat the single-input case -> o_req=1 three cycles after i_0_req, with identical data.
